// File: rtl/fft4_scheduler.sv
// fft4_scheduler: round-robin sharing of one 4-point FFT engine among
// NUM_REQ requesters, with frame latching, start/done sequencing, a single
// valid/ready result port and timeout recovery of the engine.
module fft4_scheduler #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*8*WIDTH-1:0]    req_data,
  output logic                          eng_start,
  output logic                          eng_rst,
  output logic [8*WIDTH-1:0]            eng_x,
  input  logic                          eng_done,
  input  logic [8*(WIDTH+2)-1:0]        eng_y,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [$clog2(NUM_REQ)-1:0]    res_id,
  output logic [8*(WIDTH+2)-1:0]        res_data,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned X_W   = 8 * WIDTH;
  localparam int unsigned Y_W   = 8 * (WIDTH + 2);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    cur_id_q, cur_id_d;
  logic [X_W-1:0]     eng_x_q, eng_x_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               res_valid_q, res_valid_d;
  logic [ID_W-1:0]    res_id_q, res_id_d;
  logic [Y_W-1:0]     res_data_q, res_data_d;
  logic               eng_start_q, eng_start_d;
  logic               eng_rst_q, eng_rst_d;
  logic               timeout_err_q, timeout_err_d;
  logic               busy_q, busy_d;

  logic               gnt_found;
  logic [ID_W-1:0]    gnt_idx;
  logic [ID_W-1:0]    cand;
  logic               req_hs;

  // Round-robin search: first valid requester at or after ptr.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Grant is offered only in IDLE and never while reset is applied.
  assign req_hs    = (state_q == S_IDLE) && gnt_found && rst_n;
  assign req_ready = req_hs ? (NUM_REQ'(1) << gnt_idx) : '0;

  // Next-state and output logic for the scheduling FSM.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cur_id_d      = cur_id_q;
    eng_x_d       = eng_x_q;
    cnt_d         = cnt_q;
    res_valid_d   = res_valid_q;
    res_id_d      = res_id_q;
    res_data_d    = res_data_q;
    eng_start_d   = 1'b0;
    eng_rst_d     = 1'b0;
    timeout_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_hs) begin
          eng_x_d     = req_data[32'(gnt_idx) * X_W +: X_W];
          cur_id_d    = gnt_idx;
          ptr_d       = ID_W'((32'(gnt_idx) + 32'd1) % NUM_REQ);
          eng_start_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (eng_done) begin
          res_data_d  = eng_y;
          res_id_d    = cur_id_q;
          res_valid_d = 1'b1;
          state_d     = S_OUT;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Engine never answered: reset it and drop the frame.
          eng_rst_d     = 1'b1;
          timeout_err_d = 1'b1;
          cnt_d         = '0;
          state_d       = S_IDLE;
        end
      end
      S_OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      cur_id_q      <= '0;
      eng_x_q       <= '0;
      cnt_q         <= '0;
      res_valid_q   <= 1'b0;
      res_id_q      <= '0;
      res_data_q    <= '0;
      eng_start_q   <= 1'b0;
      eng_rst_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cur_id_q      <= cur_id_d;
      eng_x_q       <= eng_x_d;
      cnt_q         <= cnt_d;
      res_valid_q   <= res_valid_d;
      res_id_q      <= res_id_d;
      res_data_q    <= res_data_d;
      eng_start_q   <= eng_start_d;
      eng_rst_q     <= eng_rst_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
    end
  end

  // Engine is held in reset along with the scheduler.
  assign eng_rst     = eng_rst_q | ~rst_n;
  assign eng_start   = eng_start_q;
  assign eng_x       = eng_x_q;
  assign res_valid   = res_valid_q;
  assign res_id      = res_id_q;
  assign res_data    = res_data_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fft4_scheduler.sv
// Directed testbench for fft4_scheduler with a behavioural 4-point FFT engine.
module tb_fft4_scheduler;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned X_W     = 8 * WIDTH;
  localparam int unsigned Y_W     = 8 * (WIDTH + 2);

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*X_W-1:0]     req_data;
  logic                       eng_start;
  logic                       eng_rst;
  logic [X_W-1:0]             eng_x;
  logic                       eng_done;
  logic [Y_W-1:0]             eng_y;
  logic                       res_valid;
  logic                       res_ready;
  logic [1:0]                 res_id;
  logic [Y_W-1:0]             res_data;
  logic                       busy;
  logic                       timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  fft4_scheduler #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .eng_start(eng_start), .eng_rst(eng_rst), .eng_x(eng_x),
    .eng_done(eng_done), .eng_y(eng_y), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_data(res_data), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [X_W-1:0] pack_x(input int r0, r1, r2, r3, i0, i1, i2, i3);
    logic [X_W-1:0] v;
    v[15:0]    = 16'(r0); v[31:16]   = 16'(r1); v[47:32]   = 16'(r2); v[63:48]   = 16'(r3);
    v[79:64]   = 16'(i0); v[95:80]   = 16'(i1); v[111:96]  = 16'(i2); v[127:112] = 16'(i3);
    return v;
  endfunction

  function automatic logic [Y_W-1:0] pack_y(input int r0, r1, r2, r3, i0, i1, i2, i3);
    logic [Y_W-1:0] v;
    v[17:0]    = 18'(r0); v[35:18]   = 18'(r1); v[53:36]   = 18'(r2); v[71:54]   = 18'(r3);
    v[89:72]   = 18'(i0); v[107:90]  = 18'(i1); v[125:108] = 18'(i2); v[143:126] = 18'(i3);
    return v;
  endfunction

  // Behavioural radix-4 DFT used as the engine.
  function automatic logic [Y_W-1:0] fft_ref(input logic [X_W-1:0] x);
    int xr[4];
    int xi[4];
    for (int k = 0; k < 4; k++) begin
      xr[k] = int'($signed(x[k*16 +: 16]));
      xi[k] = int'($signed(x[64 + k*16 +: 16]));
    end
    return pack_y(xr[0] + xr[1] + xr[2] + xr[3],
                  (xr[0] - xr[2]) + (xi[1] - xi[3]),
                  xr[0] - xr[1] + xr[2] - xr[3],
                  (xr[0] - xr[2]) - (xi[1] - xi[3]),
                  xi[0] + xi[1] + xi[2] + xi[3],
                  (xi[0] - xi[2]) - (xr[1] - xr[3]),
                  xi[0] - xi[1] + xi[2] - xi[3],
                  (xi[0] - xi[2]) + (xr[1] - xr[3]));
  endfunction

  // Engine model: samples eng_x the cycle after start, done pulse 3 cycles later.
  int             mdl_cnt = 0;
  logic           mdl_done = 1'b0;
  logic           inj_done = 1'b0;
  logic [Y_W-1:0] mdl_y = '0;
  bit             eng_hang = 1'b0;

  always @(posedge clk) begin
    if (eng_rst) begin
      mdl_cnt  <= 0;
      mdl_done <= 1'b0;
    end else if (eng_start) begin
      mdl_cnt  <= 3;
      mdl_done <= 1'b0;
      mdl_y    <= fft_ref(eng_x);
    end else if (mdl_cnt != 0) begin
      mdl_cnt  <= mdl_cnt - 1;
      mdl_done <= (mdl_cnt == 1) && !eng_hang;
    end else begin
      mdl_done <= 1'b0;
    end
  end

  assign eng_done = mdl_done | inj_done;
  assign eng_y    = mdl_y;

  // Log grants, start pulses and cycle stamps.
  int cyc_cnt   = 0;
  int start_cnt = 0;
  int grant_q[$];
  int stamp_q[$];

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (eng_start) start_cnt <= start_cnt + 1;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_valid[i] && req_ready[i]) begin
        grant_q.push_back(i);
        stamp_q.push_back(cyc_cnt);
      end
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_res(output int cyc);
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("res_valid_seen", 160'(res_valid), 160'(1));
  endtask

  task automatic set_req(input int id, input logic [X_W-1:0] v);
    req_data[id*X_W +: X_W] = v;
    req_valid[id] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int gbase;
    int s0;
    bit saw_valid;

    rst_n = 1'b0; req_valid = '0; req_data = '0; res_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_req_ready", 160'(req_ready), 160'(0));
    check("rst_eng_rst", 160'(eng_rst), 160'(1));
    check("rst_busy", 160'(busy), 160'(0));
    check("rst_res_valid", 160'(res_valid), 160'(0));
    check("rst_res_id", 160'(res_id), 160'(0));
    check("rst_res_data", 160'(res_data), 160'(0));
    check("rst_eng_start", 160'(eng_start), 160'(0));
    check("rst_eng_x", 160'(eng_x), 160'(0));
    check("rst_timeout_err", 160'(timeout_err), 160'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("eng_rst_released", 160'(eng_rst), 160'(0));

    // Single request from requester 2
    gbase = grant_q.size();
    s0 = start_cnt;
    set_req(2, pack_x(1, 2, 3, 4, 0, 0, 0, 0));
    #1;
    check("single_req_ready", 160'(req_ready), 160'(4'b0100));
    @(negedge clk);
    req_valid = '0;
    check("single_start", 160'(eng_start), 160'(1));
    check("single_busy", 160'(busy), 160'(1));
    check("single_eng_x", 160'(eng_x), 160'(pack_x(1, 2, 3, 4, 0, 0, 0, 0)));
    wait_res(cyc);
    check("single_latency", 160'(cyc), 160'(5));
    check("single_res_id", 160'(res_id), 160'(2));
    check("single_res_data", 160'(res_data), 160'(pack_y(10, -2, -2, -2, 0, 2, 0, -2)));
    @(negedge clk);
    check("single_res_drop", 160'(res_valid), 160'(0));
    check("single_busy_drop", 160'(busy), 160'(0));
    check("single_starts", 160'(start_cnt - s0), 160'(1));
    check("single_grants", 160'(grant_q.size() - gbase), 160'(1));
    check("single_grant_id", 160'(grant_q[gbase]), 160'(2));

    // Fairness from ptr=0 after reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    gbase = grant_q.size();
    for (int i = 0; i < 4; i++) set_req(i, pack_x(10 + i, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      wait_res(cyc);
      check("fair_res_id", 160'(res_id), 160'(k % 4));
      check("fair_res_data", 160'(res_data),
            160'(pack_y(10 + k % 4, 10 + k % 4, 10 + k % 4, 10 + k % 4, 0, 0, 0, 0)));
      if (k == 7) req_valid = '0;
    end
    @(negedge clk);
    check("fair_grant_count", 160'(grant_q.size() - gbase), 160'(8));
    for (int k = 0; k < 8; k++)
      check("fair_grant_order", 160'(grant_q[gbase + k]), 160'(k % 4));
    for (int k = 0; k < 7; k++)
      check("fair_period", 160'(stamp_q[gbase + k + 1] - stamp_q[gbase + k]), 160'(7));

    // Back-pressure while another requester waits
    res_ready = 1'b0;
    set_req(1, pack_x(1, 2, 3, 4, 0, 0, 0, 0));
    @(negedge clk);
    req_valid[1] = 1'b0;
    set_req(3, pack_x(7, 0, 0, 0, 0, 0, 0, 0));
    wait_res(cyc);
    check("bp_res_id", 160'(res_id), 160'(1));
    check("bp_res_data", 160'(res_data), 160'(pack_y(10, -2, -2, -2, 0, 2, 0, -2)));
    repeat (10) begin
      @(negedge clk);
      check("bp_hold_valid", 160'(res_valid), 160'(1));
      check("bp_hold_id", 160'(res_id), 160'(1));
      check("bp_hold_data", 160'(res_data), 160'(pack_y(10, -2, -2, -2, 0, 2, 0, -2)));
      check("bp_no_ready", 160'(req_ready), 160'(0));
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_accepted", 160'(res_valid), 160'(0));
    check("bp_next_ready", 160'(req_ready), 160'(4'b1000));
    @(negedge clk);
    req_valid = '0;
    wait_res(cyc);
    check("bp_next_id", 160'(res_id), 160'(3));
    check("bp_next_data", 160'(res_data), 160'(pack_y(7, 7, 7, 7, 0, 0, 0, 0)));
    @(negedge clk);

    // Timeout: engine never answers
    eng_hang = 1'b1;
    set_req(0, pack_x(9, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    req_valid = '0;
    cyc = 0;
    saw_valid = 1'b0;
    while (timeout_err !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (res_valid === 1'b1) saw_valid = 1'b1;
    end
    check("to_cycles", 160'(cyc), 160'(TIMEOUT + 1));
    check("to_eng_rst", 160'(eng_rst), 160'(1));
    check("to_busy", 160'(busy), 160'(0));
    check("to_no_result", 160'(saw_valid), 160'(0));
    @(negedge clk);
    check("to_err_pulse", 160'(timeout_err), 160'(0));
    check("to_rst_pulse", 160'(eng_rst), 160'(0));
    eng_hang = 1'b0;
    set_req(2, pack_x(0, 0, 0, 0, 3, 0, 0, 0));
    @(negedge clk);
    req_valid = '0;
    wait_res(cyc);
    check("to_next_id", 160'(res_id), 160'(2));
    check("to_next_data", 160'(res_data), 160'(pack_y(0, 0, 0, 0, 3, 3, 3, 3)));
    @(negedge clk);

    // Reset in the middle of WAIT
    set_req(1, pack_x(1, 2, 3, 4, 0, 0, 0, 0));
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_busy", 160'(busy), 160'(0));
    check("mid_res_valid", 160'(res_valid), 160'(0));
    check("mid_res_id", 160'(res_id), 160'(0));
    check("mid_res_data", 160'(res_data), 160'(0));
    check("mid_eng_x", 160'(eng_x), 160'(0));
    check("mid_eng_start", 160'(eng_start), 160'(0));
    check("mid_eng_rst", 160'(eng_rst), 160'(1));
    check("mid_timeout_err", 160'(timeout_err), 160'(0));
    rst_n = 1'b1;
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    check("late_done_busy", 160'(busy), 160'(0));
    check("late_done_valid", 160'(res_valid), 160'(0));
    @(negedge clk);
    check("late_done_valid2", 160'(res_valid), 160'(0));
    set_req(0, pack_x(5, 0, 0, 0, 0, 0, 0, 0));
    set_req(3, pack_x(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767));
    #1;
    check("mid_ptr_zero", 160'(req_ready), 160'(4'b0001));
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_res(cyc);
    check("mid_fresh_id", 160'(res_id), 160'(0));
    check("mid_fresh_data", 160'(res_data), 160'(pack_y(5, 5, 5, 5, 0, 0, 0, 0)));

    // Max magnitude frame on requester 3
    @(negedge clk);
    check("max_ready", 160'(req_ready), 160'(4'b1000));
    @(negedge clk);
    req_valid = '0;
    wait_res(cyc);
    check("max_id", 160'(res_id), 160'(3));
    check("max_data", 160'(res_data), 160'(pack_y(131068, 0, 0, 0, 131068, 0, 0, 0)));
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fft4_scheduler.md
# fft4_scheduler

Round-robin scheduler that shares one 4-point FFT engine (the `fft_4point` datapath, WIDTH-bit complex inputs and WIDTH+2-bit outputs, start/done) among NUM_REQ requesters. Each requester offers an 8-word sample frame on a valid/ready port. The scheduler:

- grants one requester at a time,
- latches its frame and sequences the engine's start/done,
- returns the 8-word result with the requester ID on a single valid/ready result port,
- recovers the engine with a reset pulse if done never arrives.

It sits between the channel front-ends and the FFT engine.

## Interface
Parameters:
- WIDTH, 16, input sample width per real/imag word
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT, 15, max cycles spent in WAIT before abort (≥ 8)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester frame valid
- req_ready  out  NUM_REQ  per-requester accept, at most one bit high
- req_data  in  NUM_REQ*8*WIDTH  per requester, packed {xi3,xi2,xi1,xi0,xr3,xr2,xr1,xr0}, xr0 in LSBs
- eng_start  out  1  engine start pulse
- eng_rst  out  1  engine reset (active-high), recovery pulse
- eng_x  out  8*WIDTH  latched frame to engine, same packing as req_data
- eng_done  in  1  engine done pulse
- eng_y  in  8*(WIDTH+2)  engine outputs, packed {yi3..yi0,yr3..yr0}
- res_valid  out  1  result available
- res_ready  in  1  result sink accept
- res_id  out  clog2(NUM_REQ)  requester index of result
- res_data  out  8*(WIDTH+2)  captured eng_y
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  one-cycle pulse on WAIT abort

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, OUT.
- **IDLE:**
  - Arbitration is round-robin. Search starts at ptr and takes the first i with req_valid[i].
  - req_ready[i] is asserted combinationally for that i only; all other bits are 0.
  - On handshake: eng_x <= req_data[i], cur_id <= i, ptr <= (i+1) mod NUM_REQ, go to ISSUE.
  - With no valid request, stay in IDLE; ptr is unchanged.
- **ISSUE:** eng_start=1 for exactly this one cycle, then go to WAIT. Clear the timeout counter.
- **WAIT:**
  - The counter increments each cycle.
  - If eng_done=1: res_data <= eng_y, res_id <= cur_id, res_valid <= 1, go to OUT.
  - Otherwise, if the counter reaches TIMEOUT: pulse eng_rst and timeout_err for 1 cycle, drop the frame (no result), go to IDLE.
  - If eng_done and the timeout coincide, eng_done wins.
- **OUT:**
  - Hold res_valid, res_id and res_data stable until res_ready=1.
  - On handshake: res_valid <= 0, go to IDLE.
  - No new request is accepted while in OUT (single outstanding frame).
- eng_x holds its value from the IDLE handshake until the next handshake. The engine samples inputs one cycle after start, so eng_x must stay stable through WAIT.
- **Grant order:**
  - ptr only advances past the granted index, which guarantees fairness.
  - A requester that drops valid before its grant loses nothing.
  - The request side has no back-pressure other than req_ready.
- eng_done seen outside WAIT is ignored.

## Timing
- **Reset** (rst_n=0 at a clock edge):
  - state=IDLE, ptr=0, eng_x=0, cur_id=0, timeout counter=0.
  - Outputs: req_ready=0, eng_start=0, res_valid=0, res_id=0, res_data=0, busy=0, timeout_err=0.
  - eng_rst=1 while rst_n=0, so the engine is reset together with the scheduler.
  - Reset mid-frame discards the frame silently.
- **Latency:** request handshake at edge E0 gives:
  - eng_start high in cycle E0..E1;
  - engine done high in cycle E4..E5;
  - res_valid high from E5.
  - This is 5 cycles from accept to result valid.
- **Throughput:** with res_ready tied 1, OUT lasts 1 cycle and the next grant is possible in the following IDLE cycle. One frame every 7 cycles.
- busy=1 from E0 until the cycle after the result handshake (or after the abort).

## Test plan
- **Single request:**
  - Stimulus: requester 2, xr = {1,2,3,4}, xi = 0, res_ready=1.
  - Required: req_ready[2] pulses once, eng_start pulses once.
  - Result at E5: res_id=2, yr = {10,-2,-2,-2}, yi = {0,2,0,-2}.
- **Fairness:** all 4 req_valid held high for 8 frames → grant order 0,1,2,3,0,1,2,3; no requester is granted twice before the others.
- **Back-pressure:** res_ready=0 for 10 cycles after res_valid → res_data and res_id stay stable, req_ready stays 0, and the result is accepted on the cycle res_ready=1.
- **Timeout:** engine model never asserts done → at cycle TIMEOUT (15) of WAIT, eng_rst and timeout_err each pulse 1 cycle, no res_valid, FSM returns to IDLE, and the next request is served normally.
- **Reset mid-operation:**
  - Stimulus: rst_n=0 during WAIT.
  - Required: next cycle, all outputs are at their reset values with ptr=0; the late eng_done is ignored.
  - Required: a fresh request for requester 0 completes with correct data.
- **Max magnitude:** all inputs = 32767 → yr0 = 131068, yi0 = 131068 (no overflow, width WIDTH+2), y1..y3 = 0.
